// File: rtl/qcldpc_pkg.sv
// rtl/qcldpc_pkg.sv - shared constants, FSM state type and Z-index helper for the QC-LDPC encoder
package qcldpc_pkg;

    localparam int NUM_Z         = 3;
    localparam int NUM_INFO_BLKS = 20;
    localparam int NUM_PAR_BLKS  = 4;

    localparam int Z_IDX_W = (NUM_Z > 1) ? $clog2(NUM_Z) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_EMIT  = 2'd3
    } seq_state_t;

    // Bit position of the set bit in a one-hot Z request (0 for an all-zero input).
    function automatic logic [Z_IDX_W-1:0] onehot_to_idx(input logic [NUM_Z-1:0] oh);
        logic [Z_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_Z; i++) begin
            if (oh[i]) begin
                idx = Z_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/qcldpc_onehot_check.sv
// rtl/qcldpc_onehot_check.sv - one-hot validation and index extraction for a Z request
module qcldpc_onehot_check #(
    parameter int W  = 3,
    parameter int IW = 2
) (
    input  logic [W-1:0]  req_z,
    output logic          is_onehot,
    output logic [IW-1:0] idx
);

    // Exactly one bit set: nonzero, and clearing the lowest set bit leaves nothing.
    always_comb begin
        is_onehot = (req_z != '0) && ((req_z & (req_z - W'(1))) == '0);
        idx       = '0;
        for (int i = 0; i < W; i++) begin
            if (req_z[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/qcldpc_encode_sequencer.sv
// rtl/qcldpc_encode_sequencer.sv - sequences one QC-LDPC code-block encode through the shared datapath
module qcldpc_encode_sequencer
    import qcldpc_pkg::*;
#(
    parameter int NUM_Z         = qcldpc_pkg::NUM_Z,
    parameter int NUM_INFO_BLKS = qcldpc_pkg::NUM_INFO_BLKS,
    parameter int NUM_PAR_BLKS  = qcldpc_pkg::NUM_PAR_BLKS,
    parameter int PIPE_LAT      = 1,
    parameter int ROM_AW        = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [NUM_Z-1:0]                req_z,
    input  logic                            abort,
    output logic                            busy,
    output logic                            cfg_err,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [NUM_Z-1:0]                z_sel,
    output logic [ROM_AW-1:0]               rom_addr,
    output logic                            acc_clr,
    output logic                            acc_en,
    output logic                            par_valid,
    input  logic                            par_ready,
    output logic [$clog2(NUM_PAR_BLKS)-1:0] par_idx,
    output logic                            par_last,
    output logic                            done
);

    localparam int IDX_W = (NUM_Z > 1) ? $clog2(NUM_Z) : 1;
    localparam int COL_W = (NUM_INFO_BLKS > 1) ? $clog2(NUM_INFO_BLKS) : 1;
    localparam int PAR_W = $clog2(NUM_PAR_BLKS);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_INFO_BLKS - 1);
    localparam logic [PAR_W-1:0] PAR_LAST = PAR_W'(NUM_PAR_BLKS - 1);
    localparam logic [2:0]       LAT_INIT = 3'(PIPE_LAT);

    seq_state_t        state;
    logic [COL_W-1:0]  col;
    logic [2:0]        lat_cnt;
    logic              req_onehot;
    logic [IDX_W-1:0]  req_idx;
    logic              par_beat;

    qcldpc_onehot_check #(
        .W  (NUM_Z),
        .IW (IDX_W)
    ) u_req_chk (
        .req_z     (req_z),
        .is_onehot (req_onehot),
        .idx       (req_idx)
    );

    // Handshake and status outputs decoded from state; abort suppresses a same-cycle info beat.
    always_comb begin
        busy      = (state != S_IDLE);
        in_ready  = (state == S_LOAD);
        acc_en    = in_ready & in_valid & ~abort;
        par_valid = (state == S_EMIT);
        par_last  = par_valid & (par_idx == PAR_LAST);
        par_beat  = par_valid & par_ready;
    end

    // Sequencer FSM with column, latency and parity-lane counters; pulses default low each cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            z_sel    <= '0;
            rom_addr <= '0;
            col      <= '0;
            lat_cnt  <= '0;
            par_idx  <= '0;
            acc_clr  <= 1'b0;
            cfg_err  <= 1'b0;
            done     <= 1'b0;
        end else begin
            acc_clr <= 1'b0;
            cfg_err <= 1'b0;
            done    <= 1'b0;
            if ((state != S_IDLE) && abort) begin
                state    <= S_IDLE;
                acc_clr  <= 1'b1;
                col      <= '0;
                par_idx  <= '0;
                rom_addr <= '0;
                lat_cnt  <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            if (req_onehot) begin
                                z_sel    <= req_z;
                                rom_addr <= ROM_AW'(req_idx) * ROM_AW'(NUM_INFO_BLKS);
                                col      <= '0;
                                acc_clr  <= 1'b1;
                                state    <= S_LOAD;
                            end else begin
                                cfg_err <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (acc_en) begin
                            if (col == COL_LAST) begin
                                if (PIPE_LAT == 0) begin
                                    state <= S_EMIT;
                                end else begin
                                    state   <= S_DRAIN;
                                    lat_cnt <= LAT_INIT;
                                end
                            end else begin
                                col      <= col + COL_W'(1);
                                rom_addr <= rom_addr + ROM_AW'(1);
                            end
                        end
                    end
                    S_DRAIN: begin
                        // One DRAIN cycle per unit of latency; leave as the count reaches zero.
                        if (lat_cnt <= 3'd1) begin
                            lat_cnt <= '0;
                            state   <= S_EMIT;
                        end else begin
                            lat_cnt <= lat_cnt - 3'd1;
                        end
                    end
                    S_EMIT: begin
                        if (par_beat) begin
                            if (par_idx == PAR_LAST) begin
                                par_idx <= '0;
                                done    <= 1'b1;
                                state   <= S_IDLE;
                            end else begin
                                par_idx <= par_idx + PAR_W'(1);
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qcldpc_encode_sequencer.sv
// tb/tb_qcldpc_encode_sequencer.sv - randomized self-checking bench for qcldpc_encode_sequencer
module tb_qcldpc_encode_sequencer;

    localparam int NINFO = 20;
    localparam int NPAR  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_i     [2];
    logic [2:0] req_z_i     [2];
    logic       abort_i     [2];
    logic       in_valid_i  [2];
    logic       par_ready_i [2];

    logic       busy_o      [2];
    logic       cfg_err_o   [2];
    logic       in_ready_o  [2];
    logic [2:0] z_sel_o     [2];
    logic [7:0] rom_addr_o  [2];
    logic       acc_clr_o   [2];
    logic       acc_en_o    [2];
    logic       par_valid_o [2];
    logic [1:0] par_idx_o   [2];
    logic       par_last_o  [2];
    logic       done_o      [2];

    int checks = 0;
    int errors = 0;

    qcldpc_encode_sequencer #(.PIPE_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .start(start_i[0]), .req_z(req_z_i[0]), .abort(abort_i[0]),
        .busy(busy_o[0]), .cfg_err(cfg_err_o[0]), .in_valid(in_valid_i[0]), .in_ready(in_ready_o[0]),
        .z_sel(z_sel_o[0]), .rom_addr(rom_addr_o[0]), .acc_clr(acc_clr_o[0]), .acc_en(acc_en_o[0]),
        .par_valid(par_valid_o[0]), .par_ready(par_ready_i[0]), .par_idx(par_idx_o[0]),
        .par_last(par_last_o[0]), .done(done_o[0])
    );

    qcldpc_encode_sequencer #(.PIPE_LAT(0)) u_lat0 (
        .clk(clk), .rst_n(rst_n), .start(start_i[1]), .req_z(req_z_i[1]), .abort(abort_i[1]),
        .busy(busy_o[1]), .cfg_err(cfg_err_o[1]), .in_valid(in_valid_i[1]), .in_ready(in_ready_o[1]),
        .z_sel(z_sel_o[1]), .rom_addr(rom_addr_o[1]), .acc_clr(acc_clr_o[1]), .acc_en(acc_en_o[1]),
        .par_valid(par_valid_o[1]), .par_ready(par_ready_i[1]), .par_idx(par_idx_o[1]),
        .par_last(par_last_o[1]), .done(done_o[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input int d, input string tag);
        check({tag, ".busy"},      busy_o[d],      0);
        check({tag, ".cfg_err"},   cfg_err_o[d],   0);
        check({tag, ".in_ready"},  in_ready_o[d],  0);
        check({tag, ".z_sel"},     z_sel_o[d],     0);
        check({tag, ".rom_addr"},  rom_addr_o[d],  0);
        check({tag, ".acc_clr"},   acc_clr_o[d],   0);
        check({tag, ".acc_en"},    acc_en_o[d],    0);
        check({tag, ".par_valid"}, par_valid_o[d], 0);
        check({tag, ".par_idx"},   par_idx_o[d],   0);
        check({tag, ".par_last"},  par_last_o[d],  0);
        check({tag, ".done"},      done_o[d],      0);
    endtask

    // Issue a start with a one-hot Z and check the first LOAD cycle.
    task automatic start_block(input int d, input int zi);
        logic [2:0] oh;
        oh = 3'(1 << zi);
        start_i[d] = 1'b1;
        req_z_i[d] = oh;
        #1;
        check("start.idle_busy", busy_o[d], 0);
        tick();
        start_i[d] = 1'b0;
        req_z_i[d] = 3'b000;
        #1;
        check("start.acc_clr", acc_clr_o[d], 1);
        check("start.busy", busy_o[d], 1);
        check("start.z_sel", z_sel_o[d], oh);
    endtask

    // Offer info blocks until n beats are accepted; ROM address follows z_idx*NINFO + beat count.
    task automatic feed(input int d, input int zi, input bit bp, input int n);
        int beats;
        int guard;
        beats = 0;
        guard = 0;
        while (beats < n && guard < 400) begin
            in_valid_i[d] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            check("load.in_ready", in_ready_o[d], 1);
            check("load.acc_en", acc_en_o[d], in_valid_i[d]);
            check("load.rom_addr", rom_addr_o[d], zi * NINFO + beats);
            check("load.par_valid", par_valid_o[d], 0);
            if (in_valid_i[d]) beats++;
            guard++;
            tick();
        end
        in_valid_i[d] = 1'b0;
        if (beats != n) check("load.timeout", beats, n);
    endtask

    // Latency wait: upstream keeps offering data that must not be taken.
    task automatic drain(input int d, input int lat);
        for (int i = 0; i < lat; i++) begin
            in_valid_i[d] = 1'b1;
            #1;
            check("drain.busy", busy_o[d], 1);
            check("drain.in_ready", in_ready_o[d], 0);
            check("drain.acc_en", acc_en_o[d], 0);
            check("drain.par_valid", par_valid_o[d], 0);
            tick();
        end
        in_valid_i[d] = 1'b0;
    endtask

    // Collect parity beats until n are accepted; with bp, stall 5 cycles first then random ready.
    task automatic emit(input int d, input bit bp, input int n);
        int p;
        int guard;
        int stall;
        p = 0;
        guard = 0;
        stall = bp ? 5 : 0;
        while (p < n && guard < 200) begin
            par_ready_i[d] = (stall > 0) ? 1'b0 : (bp ? 1'($urandom_range(0, 1)) : 1'b1);
            #1;
            check("emit.par_valid", par_valid_o[d], 1);
            check("emit.par_idx", par_idx_o[d], p);
            check("emit.par_last", par_last_o[d], (p == NPAR - 1) ? 1 : 0);
            check("emit.in_ready", in_ready_o[d], 0);
            if (par_ready_i[d]) p++;
            if (stall > 0) stall--;
            guard++;
            tick();
        end
        par_ready_i[d] = 1'b0;
        if (p != n) check("emit.timeout", p, n);
    endtask

    task automatic run_block(input int d, input int zi, input int lat, input bit bp);
        start_block(d, zi);
        feed(d, zi, bp, NINFO);
        drain(d, lat);
        emit(d, bp, NPAR);
        #1;
        check("end.done", done_o[d], 1);
        check("end.busy", busy_o[d], 0);
        check("end.par_valid", par_valid_o[d], 0);
        tick();
        #1;
        check("end.done_pulse", done_o[d], 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start_i[d] = 1'b0;
            req_z_i[d] = 3'b000;
            abort_i[d] = 1'b0;
            in_valid_i[d] = 1'b0;
            par_ready_i[d] = 1'b0;
        end
        tick();
        tick();
        check_all_zero(0, "reset0");
        check_all_zero(1, "reset1");
        rst_n = 1'b1;
        tick();

        // Nominal Z=54, PIPE_LAT=1
        run_block(0, 1, 1, 1'b0);

        // Random Z with upstream and downstream backpressure
        run_block(0, $urandom_range(0, 2), 1, 1'b1);

        // Bad config: two non-one-hot requests back to back
        start_i[0] = 1'b1;
        req_z_i[0] = 3'b011;
        tick();
        req_z_i[0] = 3'b000;
        #1;
        check("badcfg.err1", cfg_err_o[0], 1);
        check("badcfg.busy1", busy_o[0], 0);
        check("badcfg.clr1", acc_clr_o[0], 0);
        tick();
        start_i[0] = 1'b0;
        #1;
        check("badcfg.err2", cfg_err_o[0], 1);
        check("badcfg.busy2", busy_o[0], 0);
        check("badcfg.clr2", acc_clr_o[0], 0);
        tick();
        #1;
        check("badcfg.err_low", cfg_err_o[0], 0);
        check("badcfg.busy3", busy_o[0], 0);
        tick();

        // Abort at col=7 with a beat offered and a stray start present
        start_block(0, 1);
        feed(0, 1, 1'b0, 7);
        in_valid_i[0] = 1'b1;
        abort_i[0] = 1'b1;
        start_i[0] = 1'b1;
        req_z_i[0] = 3'b011;
        #1;
        check("abort.acc_en", acc_en_o[0], 0);
        check("abort.rom_addr", rom_addr_o[0], NINFO + 7);
        tick();
        in_valid_i[0] = 1'b0;
        abort_i[0] = 1'b0;
        start_i[0] = 1'b0;
        req_z_i[0] = 3'b000;
        #1;
        check("abort.busy", busy_o[0], 0);
        check("abort.acc_clr", acc_clr_o[0], 1);
        check("abort.done", done_o[0], 0);
        check("abort.cfg_err", cfg_err_o[0], 0);
        tick();
        run_block(0, 2, 1, 1'b0);

        // Z=27 with zero datapath latency
        run_block(1, 0, 0, 1'b0);

        // Reset during EMIT at par_idx=2, with a start in the reset cycle
        start_block(0, 0);
        feed(0, 0, 1'b0, NINFO);
        drain(0, 1);
        emit(0, 1'b0, 2);
        #1;
        check("rstemit.par_idx", par_idx_o[0], 2);
        check("rstemit.par_valid", par_valid_o[0], 1);
        rst_n = 1'b0;
        start_i[0] = 1'b1;
        req_z_i[0] = 3'b001;
        tick();
        rst_n = 1'b1;
        start_i[0] = 1'b0;
        req_z_i[0] = 3'b000;
        #1;
        check_all_zero(0, "rstemit");
        tick();
        #1;
        check("rstemit.busy_after", busy_o[0], 0);
        check("rstemit.clr_after", acc_clr_o[0], 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
